// File: rtl/vsa_mem_pkg.sv
// Shared definitions for the VSA memory arbiter: state encoding and the
// default address/data widths used by the VSA cores.
package vsa_mem_pkg;

    localparam int VSA_AW = 5;
    localparam int VSA_DW = 5;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_RESP  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        ISSUE = ST_ISSUE,
        WAIT  = ST_WAIT,
        RESP  = ST_RESP
    } arb_state_t;

endpackage

// File: rtl/vsa_rr_pick.sv
// Combinational round-robin picker: searches upward from rr_ptr (mod NREQ)
// and returns the first active requester as one-hot and binary index.
module vsa_rr_pick #(
    parameter int NREQ = 2,
    parameter int IW   = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   rr_ptr,
    output logic [NREQ-1:0] win_oh,
    output logic [IW-1:0]   win_idx
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    // Walk offsets from the far end down so the offset closest to rr_ptr wins.
    always_comb begin
        logic [IW-1:0] pos;
        win_oh  = '0;
        win_idx = '0;
        pos     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = wrap_add(rr_ptr, k);
            if (req[pos]) begin
                win_oh      = '0;
                win_oh[pos] = 1'b1;
                win_idx     = pos;
            end
        end
    end

endmodule

// File: rtl/vsa_mem_arbiter.sv
// Round-robin arbiter sharing one fixed-latency single-ported memory among
// NREQ requesters, with a single transaction outstanding at a time.
module vsa_mem_arbiter
    import vsa_mem_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int AW      = VSA_AW,
    parameter int DW      = VSA_DW,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   req_wr,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rvalid,
    output logic [DW-1:0]     rdata,
    output logic              busy,
    output logic              mem_en,
    output logic              mem_wr,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = 3;

    arb_state_t      state;
    arb_state_t      state_nxt;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   sel;
    logic [IW-1:0]   win_idx;
    logic [NREQ-1:0] win_oh;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [DW-1:0]   wdata_q;
    logic [DW-1:0]   rdata_q;
    logic [CW-1:0]   cnt;

    vsa_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .win_oh  (win_oh),
        .win_idx (win_idx)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gnt       = '0;
        rvalid    = '0;
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (|req) state_nxt = ISSUE;
            end
            ISSUE: begin
                mem_en    = 1'b1;
                mem_wr    = wr_q;
                gnt[sel]  = 1'b1;
                state_nxt = wr_q ? IDLE : WAIT;
            end
            WAIT: begin
                if (cnt == '0) state_nxt = RESP;
            end
            RESP: begin
                rvalid[sel] = 1'b1;
                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Request fields are captured once in IDLE; later input changes are ignored.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr  <= '0;
            sel     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel     <= win_idx;
                        wr_q    <= |(win_oh & req_wr);
                        addr_q  <= req_addr[int'(win_idx)*AW +: AW];
                        wdata_q <= req_wdata[int'(win_idx)*DW +: DW];
                    end
                end
                ISSUE: begin
                    rr_ptr <= (sel == IW'(NREQ - 1)) ? '0 : sel + 1'b1;
                    cnt    <= CW'(MEM_LAT - 1);
                end
                WAIT: begin
                    if (cnt == '0) rdata_q <= mem_rdata;
                    else           cnt     <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_vsa_mem_arbiter.sv
// Directed bench for vsa_mem_arbiter: three instances cover NREQ=2/MEM_LAT=1,
// NREQ=3 pointer wrap, and MEM_LAT=3 with reset during a pending read.
module tb_vsa_mem_arbiter;

    logic clock;
    logic rst_n_ab;
    logic rst_n_c;
    int   n_chk = 0;
    int   n_err = 0;

    // Instance A: NREQ=2, MEM_LAT=1
    logic [1:0] req_a, wr_a, gnt_a, rvalid_a;
    logic [9:0] addr_a, wdata_a;
    logic [4:0] rdata_a, maddr_a, mwdata_a, mrdata_a;
    logic       busy_a, men_a, mwr_a;

    // Instance B: NREQ=3, MEM_LAT=1, writes only
    logic [2:0]  req_b, wr_b, gnt_b, rvalid_b;
    logic [14:0] addr_b, wdata_b;
    logic [4:0]  rdata_b, maddr_b, mwdata_b;
    logic        busy_b, men_b, mwr_b;

    // Instance C: NREQ=2, MEM_LAT=3
    logic [1:0] req_c, wr_c, gnt_c, rvalid_c;
    logic [9:0] addr_c, wdata_c;
    logic [4:0] rdata_c, maddr_c, mwdata_c, mrdata_c;
    logic       busy_c, men_c, mwr_c;

    vsa_mem_arbiter #(.NREQ(2), .AW(5), .DW(5), .MEM_LAT(1)) u_a (
        .clock(clock), .reset_n(rst_n_ab), .req(req_a), .req_wr(wr_a),
        .req_addr(addr_a), .req_wdata(wdata_a), .gnt(gnt_a), .rvalid(rvalid_a),
        .rdata(rdata_a), .busy(busy_a), .mem_en(men_a), .mem_wr(mwr_a),
        .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_rdata(mrdata_a)
    );

    vsa_mem_arbiter #(.NREQ(3), .AW(5), .DW(5), .MEM_LAT(1)) u_b (
        .clock(clock), .reset_n(rst_n_ab), .req(req_b), .req_wr(wr_b),
        .req_addr(addr_b), .req_wdata(wdata_b), .gnt(gnt_b), .rvalid(rvalid_b),
        .rdata(rdata_b), .busy(busy_b), .mem_en(men_b), .mem_wr(mwr_b),
        .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_rdata(5'd0)
    );

    vsa_mem_arbiter #(.NREQ(2), .AW(5), .DW(5), .MEM_LAT(3)) u_c (
        .clock(clock), .reset_n(rst_n_c), .req(req_c), .req_wr(wr_c),
        .req_addr(addr_c), .req_wdata(wdata_c), .gnt(gnt_c), .rvalid(rvalid_c),
        .rdata(rdata_c), .busy(busy_c), .mem_en(men_c), .mem_wr(mwr_c),
        .mem_addr(maddr_c), .mem_wdata(mwdata_c), .mem_rdata(mrdata_c)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory models: contents start as addr ^ 5'h19, data appears MEM_LAT cycles after mem_en
    logic [4:0] mem_a [32];
    logic [4:0] pipe_a;
    always @(posedge clock) begin
        if (!rst_n_ab) begin
            for (int i = 0; i < 32; i++) mem_a[i] <= 5'(i) ^ 5'h19;
            pipe_a <= '0;
        end else if (men_a) begin
            pipe_a <= mem_a[maddr_a];
            if (mwr_a) mem_a[maddr_a] <= mwdata_a;
        end
    end
    assign mrdata_a = pipe_a;

    logic [4:0] mem_c [32];
    logic [4:0] pipe_c [3];
    always @(posedge clock) begin
        if (!rst_n_c) begin
            for (int i = 0; i < 32; i++) mem_c[i] <= 5'(i) ^ 5'h19;
            for (int j = 0; j < 3; j++) pipe_c[j] <= '0;
        end else begin
            pipe_c[0] <= men_c ? mem_c[maddr_c] : 5'h00;
            pipe_c[1] <= pipe_c[0];
            pipe_c[2] <= pipe_c[1];
            if (men_c && mwr_c) mem_c[maddr_c] <= mwdata_c;
        end
    end
    assign mrdata_c = pipe_c[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [1:0] exp2 [6];
    logic [2:0] exp3 [6];
    logic       seen;

    initial begin
        rst_n_ab = 1'b0; rst_n_c = 1'b0;
        req_a = '0; wr_a = '0; addr_a = '0; wdata_a = '0;
        req_b = '0; wr_b = '0; addr_b = '0; wdata_b = '0;
        req_c = '0; wr_c = '0; addr_c = '0; wdata_c = '0;
        repeat (3) tick();

        check("rst_gnt", 32'(gnt_a), 0);
        check("rst_rvalid", 32'(rvalid_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_mem_en", 32'(men_a), 0);
        check("rst_mem_addr", 32'(maddr_a), 0);
        check("rst_rdata", 32'(rdata_a), 0);
        check("rst_busy_c", 32'(busy_c), 0);

        rst_n_ab = 1'b1; rst_n_c = 1'b1;
        tick();

        // 1. single read by requester 0
        req_a = 2'b01; wr_a = 2'b00; addr_a = {5'h00, 5'h0A};
        tick();
        check("t1_gnt", 32'(gnt_a), 32'h1);
        check("t1_mem_en", 32'(men_a), 1);
        check("t1_mem_wr", 32'(mwr_a), 0);
        check("t1_mem_addr", 32'(maddr_a), 32'h0A);
        check("t1_busy", 32'(busy_a), 1);
        req_a = 2'b00;
        tick();
        check("t1_wait_rvalid", 32'(rvalid_a), 0);
        check("t1_wait_gnt", 32'(gnt_a), 0);
        tick();
        check("t1_rvalid", 32'(rvalid_a), 32'h1);
        check("t1_rdata", 32'(rdata_a), 32'h13);
        tick();
        check("t1_idle_busy", 32'(busy_a), 0);
        check("t1_idle_rvalid", 32'(rvalid_a), 0);

        // 2. requester 1 writes 0x1F to 0x04, then reads it back
        req_a = 2'b10; wr_a = 2'b10; addr_a = {5'h04, 5'h00}; wdata_a = {5'h1F, 5'h00};
        tick();
        check("t2_wr_gnt", 32'(gnt_a), 32'h2);
        check("t2_wr_mem_wr", 32'(mwr_a), 1);
        check("t2_wr_mem_addr", 32'(maddr_a), 32'h04);
        check("t2_wr_mem_wdata", 32'(mwdata_a), 32'h1F);
        wr_a = 2'b00;
        tick();
        check("t2_idle_mem_wr", 32'(mwr_a), 0);
        check("t2_idle_mem_en", 32'(men_a), 0);
        check("t2_hold_mem_addr", 32'(maddr_a), 32'h04);
        tick();
        check("t2_rd_gnt", 32'(gnt_a), 32'h2);
        check("t2_rd_mem_wr", 32'(mwr_a), 0);
        req_a = 2'b00;
        tick();
        tick();
        check("t2_rvalid", 32'(rvalid_a), 32'h2);
        check("t2_rdata", 32'(rdata_a), 32'h1F);
        tick();

        // 3. contention, NREQ=2, continuous requests
        exp2 = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
        req_a = 2'b11; wr_a = 2'b11; addr_a = {5'h11, 5'h10}; wdata_a = {5'h02, 5'h01};
        for (int n = 0; n < 6; n++) begin
            tick();
            check($sformatf("t3_gnt%0d", n), 32'(gnt_a), 32'(exp2[n]));
            if (n == 5) req_a = 2'b00;
            tick();
        end
        check("t3_idle_busy", 32'(busy_a), 0);

        // 3b. pointer wrap with NREQ=3
        exp3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        req_b = 3'b111; wr_b = 3'b111; addr_b = {5'h12, 5'h11, 5'h10}; wdata_b = {5'h03, 5'h02, 5'h01};
        for (int n = 0; n < 6; n++) begin
            tick();
            check($sformatf("t3b_gnt%0d", n), 32'(gnt_b), 32'(exp3[n]));
            if (n == 5) begin
                check("t3b_mem_addr", 32'(maddr_b), 32'h12);
                req_b = 3'b000;
            end
            tick();
        end

        // 6. withdrawn request, then address change after sampling
        req_a = 2'b01; wr_a = 2'b00; addr_a = {5'h00, 5'h08};
        #3;
        req_a = 2'b00;
        tick();
        check("t6_no_gnt", 32'(gnt_a), 0);
        check("t6_no_mem_en", 32'(men_a), 0);
        check("t6_no_busy", 32'(busy_a), 0);
        req_a = 2'b10; addr_a = {5'h07, 5'h00};
        tick();
        check("t6_gnt", 32'(gnt_a), 32'h2);
        req_a = 2'b00; addr_a = {5'h1C, 5'h00};
        #2;
        check("t6_mem_addr_issue", 32'(maddr_a), 32'h07);
        tick();
        check("t6_mem_addr_wait", 32'(maddr_a), 32'h07);
        tick();
        check("t6_rvalid", 32'(rvalid_a), 32'h2);
        check("t6_rdata", 32'(rdata_a), 32'h1E);
        tick();

        // 4. MEM_LAT=3 read
        req_c = 2'b01; wr_c = 2'b00; addr_c = {5'h00, 5'h03};
        tick();
        check("t4_gnt", 32'(gnt_c), 32'h1);
        check("t4_busy_t1", 32'(busy_c), 1);
        req_c = 2'b00;
        for (int n = 2; n <= 4; n++) begin
            tick();
            check($sformatf("t4_rvalid_t%0d", n), 32'(rvalid_c), 0);
            check($sformatf("t4_busy_t%0d", n), 32'(busy_c), 1);
        end
        tick();
        check("t4_rvalid_t5", 32'(rvalid_c), 32'h1);
        check("t4_rdata", 32'(rdata_c), 32'h1A);
        check("t4_busy_t5", 32'(busy_c), 1);
        tick();
        check("t4_busy_t6", 32'(busy_c), 0);

        // 5. reset during WAIT
        req_c = 2'b10; addr_c = {5'h05, 5'h00};
        tick();
        check("t5_gnt", 32'(gnt_c), 32'h2);
        req_c = 2'b00;
        tick();
        rst_n_c = 1'b0;
        #1;
        check("t5_rst_busy", 32'(busy_c), 0);
        check("t5_rst_gnt", 32'(gnt_c), 0);
        check("t5_rst_rvalid", 32'(rvalid_c), 0);
        check("t5_rst_mem_en", 32'(men_c), 0);
        check("t5_rst_mem_addr", 32'(maddr_c), 0);
        check("t5_rst_rdata", 32'(rdata_c), 0);
        repeat (2) tick();
        rst_n_c = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (rvalid_c != 2'b00) seen = 1'b1;
        end
        check("t5_no_rvalid", 32'(seen), 0);
        req_c = 2'b11; wr_c = 2'b11; addr_c = {5'h09, 5'h08};
        tick();
        check("t5_first_gnt", 32'(gnt_c), 32'h1);
        req_c = 2'b00;
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
